// File: rtl/asm_out_monitor.sv
// Receive-side monitor for the A/B/C ASM status code stream: locks onto the
// sequence, flags illegal transitions and mirrors the generator's x/y registers.
module asm_out_monitor #(
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned CVIS_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    input  logic [2:0]        code_i,
    input  logic              clr_err_i,
    output logic              synced_o,
    output logic [1:0]        phase_o,
    output logic [CNT_W-1:0]  x_o,
    output logic [CNT_W-1:0]  y_o,
    output logic [CVIS_W-1:0] cvis_o,
    output logic              err_o,
    output logic [ERR_W-1:0]  err_cnt_o
);

    typedef enum logic [1:0] {HUNT, EXP_B, EXP_AC, EXP_A} state_t;

    localparam logic [2:0] CODE_A = 3'b100;
    localparam logic [2:0] CODE_B = 3'b011;
    localparam logic [2:0] CODE_C = 3'b010;

    state_t state;
    logic   expected;
    logic   violation;

    always_comb begin
        expected = 1'b0;
        case (state)
            HUNT:    expected = 1'b1;
            EXP_B:   expected = (code_i == CODE_B);
            EXP_AC:  expected = (code_i == CODE_A) || (code_i == CODE_C);
            EXP_A:   expected = (code_i == CODE_A);
            default: expected = 1'b0;
        endcase
    end

    // HUNT never reports an error; everything there is ignored until an A.
    assign violation = valid_i && (state != HUNT) && !expected;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= HUNT;
            synced_o  <= 1'b0;
            phase_o   <= 2'd0;
            x_o       <= '0;
            y_o       <= '0;
            cvis_o    <= '0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o <= violation;

            if (clr_err_i)
                err_cnt_o <= violation ? ERR_W'(1) : '0;
            else if (violation && (err_cnt_o != '1))
                err_cnt_o <= err_cnt_o + ERR_W'(1);

            if (valid_i) begin
                if ((code_i == CODE_A) && ((state == HUNT) || violation)) begin
                    // Fresh lock, either from HUNT or resync on an unexpected A.
                    state    <= EXP_B;
                    synced_o <= 1'b1;
                    phase_o  <= 2'd1;
                    x_o      <= '0;
                    y_o      <= '0;
                    cvis_o   <= '0;
                end else if (violation) begin
                    state    <= HUNT;
                    synced_o <= 1'b0;
                    phase_o  <= 2'd0;
                end else if (state != HUNT) begin
                    case (code_i)
                        CODE_A: begin
                            state   <= EXP_B;
                            phase_o <= 2'd1;
                            x_o     <= '0;
                            y_o     <= '0;
                        end
                        CODE_B: begin
                            state   <= EXP_AC;
                            phase_o <= 2'd2;
                            y_o     <= x_o;
                        end
                        CODE_C: begin
                            state   <= EXP_A;
                            phase_o <= 2'd3;
                            y_o     <= x_o;
                            x_o     <= x_o + CNT_W'(1);
                            cvis_o  <= cvis_o + CVIS_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
